// File: rtl/wb_timer.sv
// wb_timer: Wishbone slave 32-bit prescaled up-counter with compare match, auto-reload and level irq
module wb_timer #(
  parameter int ADR_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADR_WIDTH-1:0] wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic                 wbs_we_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  output logic [31:0]          wbs_dat_o,
  output logic                 wbs_ack_o,
  output logic                 wbs_err_o,
  output logic                 wbs_rty_o,
  output logic                 irq_o
);
  logic [2:0]  ctrl, ctrl_t, ctrl_n;
  logic [15:0] prescale, pcnt, pcnt_n;
  logic [31:0] count, count_n, compare, rdata, wmask, wdata;
  logic        match, match_n;
  logic [2:0]  idx;
  logic        req, mapped, wr, tick, hit;
  logic        unused;

  assign unused    = ^{wbs_adr_i[ADR_WIDTH-1:5], wbs_adr_i[1:0]};
  assign wbs_rty_o = 1'b0;
  assign irq_o     = match & ctrl[2];

  // bus decode, read mux and byte-merged write data against the addressed register
  always_comb begin
    idx    = wbs_adr_i[4:2];
    req    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~wbs_err_o;
    mapped = idx <= 3'd4;
    wr     = req & mapped & wbs_we_i;
    wmask  = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    rdata  = idx == 3'd0 ? {29'd0, ctrl} :
             idx == 3'd1 ? {16'd0, prescale} :
             idx == 3'd2 ? count :
             idx == 3'd3 ? compare :
             idx == 3'd4 ? {31'd0, match} : 32'd0;
    wdata  = (rdata & ~wmask) | (wbs_dat_i & wmask);
  end

  // timer next state: bus writes override tick effects, match uses pre-write COUNT, set beats W1C
  always_comb begin
    tick    = ctrl[0] & (pcnt == prescale);
    hit     = tick & (count == compare);
    ctrl_t  = {ctrl[2:1], ctrl[0] & ~(hit & ~ctrl[1])};
    ctrl_n  = wr & (idx == 3'd0) ? (ctrl_t & ~wmask[2:0]) | (wbs_dat_i[2:0] & wmask[2:0]) : ctrl_t;
    count_n = wr & (idx == 3'd2) ? wdata :
              hit ? (ctrl[1] ? 32'd0 : count) :
              tick ? count + 32'd1 : count;
    pcnt_n  = (~ctrl[0] | ~ctrl_n[0] | tick | (wr & (idx == 3'd1) & |wbs_sel_i[1:0])) ? 16'd0 : pcnt + 16'd1;
    match_n = hit | (match & ~(wr & (idx == 3'd4) & wbs_sel_i[0] & wbs_dat_i[0]));
  end

  // register file and prescaler state
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl     <= 3'd0;
      prescale <= 16'd0;
      pcnt     <= 16'd0;
      count    <= 32'd0;
      compare  <= 32'd0;
      match    <= 1'b0;
    end else begin
      ctrl     <= ctrl_n;
      prescale <= wr & (idx == 3'd1) ? wdata[15:0] : prescale;
      pcnt     <= pcnt_n;
      count    <= count_n;
      compare  <= wr & (idx == 3'd3) ? wdata : compare;
      match    <= match_n;
    end
  end

  // single-cycle registered termination; read data only accompanies a read ack
  always_ff @(posedge clk) begin
    if (rst) begin
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= 32'd0;
    end else begin
      wbs_ack_o <= req & mapped;
      wbs_err_o <= req & ~mapped;
      wbs_dat_o <= req & mapped & ~wbs_we_i ? rdata : 32'd0;
    end
  end
endmodule

// File: tb/tb_wb_timer.sv
// tb_wb_timer: directed and randomized checks of wb_timer against a tick-level reference model
module tb_wb_timer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] adr = '0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic [31:0] dat_o;
  logic        ack, err, rty, irq;
  int          checks = 0, errors = 0, edges = 0;

  wb_timer #(.ADR_WIDTH(24)) dut (
    .clk(clk), .rst(rst), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_sel_i(sel),
    .wbs_we_i(we), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_dat_o(dat_o),
    .wbs_ack_o(ack), .wbs_err_o(err), .wbs_rty_o(rty), .irq_o(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one request sampled at edge n, response captured in the following cycle, then one idle edge
  task automatic xfer(input logic w, input logic [2:0] i, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic a, output logic e, output int n);
    @(negedge clk);
    adr = {19'd0, i, 2'b00}; dat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    n = edges; rd = dat_o; a = ack; e = err;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    chk("one_cycle_term", {30'd0, ack, err}, 32'd0);
  endtask

  task automatic do_wr(input logic [2:0] i, input logic [31:0] d, input logic [3:0] s, output int n);
    logic [31:0] r;
    logic a, e;
    xfer(1'b1, i, d, s, r, a, e, n);
    chk("wr_ack", {30'd0, a, e}, 32'd2);
  endtask

  task automatic do_rd(input logic [2:0] i, output logic [31:0] r, output int n);
    logic a, e;
    xfer(1'b0, i, 32'd0, 4'hF, r, a, e, n);
    chk("rd_ack", {30'd0, a, e}, 32'd2);
  endtask

  // enabled at edge e; state visible to a read sampled at edge r reflects ticks at edges e+(p+1)k < r
  task automatic model(input int e, input int p, input logic [31:0] c0, input logic [31:0] cmp,
                       input logic ar, input int r, output logic [31:0] c, output logic m, output logic en);
    int nt;
    nt = (r - 1 - e) / (p + 1);
    c = c0; m = 1'b0; en = 1'b1;
    for (int k = 0; k < nt && en; k++) begin
      if (c == cmp) begin
        m = 1'b1;
        if (ar) c = 32'd0;
        else en = 1'b0;
      end else c = c + 32'd1;
    end
  endtask

  initial begin
    logic [31:0] r, mc, cmp, c0;
    logic a, e, mm, men, ar, ie;
    int n, en_edge, p, w;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {dat_o[31:4], ack, err, rty, irq}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_rd(3'(i), r, n);
      chk("reset_read", r, 32'd0);
    end
    chk("reset_irq", {31'd0, irq}, 32'd0);

    xfer(1'b1, 3'd6, 32'hDEADBEEF, 4'hF, r, a, e, n);
    chk("unmapped_wr_term", {30'd0, a, e}, 32'd1);
    xfer(1'b0, 3'd5, 32'd0, 4'hF, r, a, e, n);
    chk("unmapped_rd_term", {30'd0, a, e}, 32'd1);
    chk("unmapped_rd_data", r, 32'd0);
    do_rd(3'd2, r, n);
    chk("after_err_count", r, 32'd0);
    do_rd(3'd3, r, n);
    chk("after_err_compare", r, 32'd0);

    do_wr(3'd3, 32'h11223344, 4'hF, n);
    do_wr(3'd3, 32'h0000AB00, 4'b0010, n);
    do_rd(3'd3, r, n);
    chk("byte_write", r, 32'h1122AB44);
    do_wr(3'd3, 32'hFFFFFFFF, 4'b0000, n);
    do_rd(3'd3, r, n);
    chk("sel0_write", r, 32'h1122AB44);
    do_wr(3'd1, 32'hFFFF0003, 4'hF, n);
    do_rd(3'd1, r, n);
    chk("prescale_mask", r, 32'h00000003);

    do_wr(3'd0, 32'd0, 4'hF, n);
    do_wr(3'd4, 32'd1, 4'hF, n);
    do_wr(3'd2, 32'd0, 4'hF, n);
    do_wr(3'd3, 32'd5, 4'hF, n);
    do_wr(3'd0, 32'h7, 4'hF, en_edge);
    for (int k = 2; k <= 26; k++) begin
      @(posedge clk); #1;
      chk("reload_irq_rise", {31'd0, irq}, {31'd0, k >= 24});
    end
    do_rd(3'd2, r, n);
    model(en_edge, 3, 32'd0, 32'd5, 1'b1, n, mc, mm, men);
    chk("reload_count", r, mc);
    do_rd(3'd4, r, n);
    chk("reload_status", r, 32'd1);
    do_rd(3'd0, r, n);
    chk("reload_ctrl", r, 32'h7);
    do_wr(3'd4, 32'd1, 4'hF, n);
    chk("reload_irq_clear", {31'd0, irq}, 32'd0);

    do_wr(3'd0, 32'd0, 4'hF, n);
    do_wr(3'd4, 32'd1, 4'hF, n);
    do_wr(3'd2, 32'd0, 4'hF, n);
    do_wr(3'd0, 32'h5, 4'hF, en_edge);
    for (int k = 2; k <= 26; k++) begin
      @(posedge clk); #1;
      chk("oneshot_irq_rise", {31'd0, irq}, {31'd0, k >= 24});
    end
    do_rd(3'd0, r, n);
    chk("oneshot_ctrl", r, 32'h4);
    do_rd(3'd2, r, n);
    chk("oneshot_count", r, 32'd5);
    do_wr(3'd4, 32'd0, 4'hF, n);
    chk("w0_status_irq", {31'd0, irq}, 32'd1);
    do_wr(3'd4, 32'd1, 4'hF, n);
    chk("w1c_status_irq", {31'd0, irq}, 32'd0);

    do_wr(3'd0, 32'd0, 4'hF, n);
    do_wr(3'd2, 32'hFFFFFFFF, 4'hF, n);
    do_wr(3'd3, 32'h10, 4'hF, n);
    do_wr(3'd1, 32'd0, 4'hF, n);
    do_wr(3'd0, 32'h1, 4'hF, en_edge);
    do_rd(3'd2, r, n);
    chk("wrap_edge", n - en_edge, 32'd2);
    chk("wrap_count", r, 32'd0);
    do_rd(3'd4, r, n);
    chk("wrap_status", r, 32'd0);

    do_wr(3'd0, 32'd0, 4'hF, n);
    do_wr(3'd4, 32'd1, 4'hF, n);
    do_wr(3'd2, 32'd7, 4'hF, n);
    do_wr(3'd3, 32'd7, 4'hF, n);
    do_wr(3'd1, 32'd1, 4'hF, n);
    do_wr(3'd0, 32'h3, 4'hF, en_edge);
    do_wr(3'd2, 32'h100, 4'hF, n);
    chk("collide_edge", n - en_edge, 32'd2);
    do_rd(3'd4, r, n);
    chk("collide_status", r, 32'd1);
    do_rd(3'd2, r, n);
    chk("collide_count", r, 32'h101);

    for (int it = 0; it < 12; it++) begin
      p   = int'($urandom_range(3, 0));
      cmp = $urandom_range(12, 0);
      c0  = $urandom_range(cmp, 0);
      ar  = 1'($urandom_range(1, 0));
      ie  = 1'($urandom_range(1, 0));
      w   = int'($urandom_range(60, 0));
      do_wr(3'd0, 32'd0, 4'hF, n);
      do_wr(3'd4, 32'd1, 4'hF, n);
      do_wr(3'd1, 32'(p), 4'hF, n);
      do_wr(3'd3, cmp, 4'hF, n);
      do_wr(3'd2, c0, 4'hF, n);
      do_wr(3'd0, {29'd0, ie, ar, 1'b1}, 4'hF, en_edge);
      repeat (w) @(posedge clk);
      do_rd(3'd2, r, n);
      model(en_edge, p, c0, cmp, ar, n, mc, mm, men);
      chk("rnd_count", r, mc);
      do_rd(3'd4, r, n);
      model(en_edge, p, c0, cmp, ar, n, mc, mm, men);
      chk("rnd_status", r, {31'd0, mm});
      do_rd(3'd0, r, n);
      model(en_edge, p, c0, cmp, ar, n, mc, mm, men);
      chk("rnd_ctrl", r, {29'd0, ie, ar, men});
      model(en_edge, p, c0, cmp, ar, n + 2, mc, mm, men);
      chk("rnd_irq", {31'd0, irq}, {31'd0, mm & ie});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
